pb_bcd_display: RTL and testbench
=================================

Name: pb_bcd_display

Overview:
- Downstream stage of the push-button path; consumes the single-cycle debounced pulse from the pulse/counter front end.
- Keeps a two-digit BCD up/down event count, 00..MAX_COUNT.
- Drives a time-multiplexed two-digit common-anode seven-segment display through shared segment lines and per-digit enables.
- Direction comes from board switch sw1.

Parameters:
- MAX_COUNT, 99: highest count value; must be 1..99. The count wraps between MAX_COUNT and 00.
- REFRESH_DIV, 50000: clk cycles each digit stays enabled; must be ≥ 2. Use 4 in simulation.
- BLANK_LZ, 1: when 1, the tens digit is blanked while the tens value is 0.

Ports:
- clk  in  1  system clock; all state on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- pulse  in  1  single-cycle count event from the upstream pulse stage.
- sw1  in  1  direction: 1 = up, 0 = down; sampled on cycles where pulse=1.
- clr  in  1  synchronous clear of the count, active high.
- ones  out  4  BCD units digit (registered).
- tens  out  4  BCD tens digit (registered).
- wrap  out  1  one-cycle flag marking a count wrap.
- seg  out  7  segment cathodes, active low; seg[0]=a … seg[6]=g.
- en0  out  1  units digit anode enable, active low.
- en1  out  1  tens digit anode enable, active low.

Behaviour:
- Reset (rst_n=0, asynchronous, any time): all registers clear immediately, regardless of clk.
  - ones=0, tens=0, wrap=0.
  - Refresh counter=0; digit select sel=0 (units).
  - en0=0, en1=1, seg=7'b1000000 (the glyph "0").
- Deassertion of rst_n is synchronized by the integrating top level; this block takes no action on it.

Counter:
- Priority per cycle: clr > pulse > hold.
- clr=1: count returns to 00 on the next edge and wrap=0. Any pulse in the same cycle is discarded.
- pulse=1 and sw1=1 (up):
  - If the count equals MAX_COUNT, it goes to 00 and wrap=1 for one cycle.
  - Otherwise it increments. When ones=9 it carries: ones becomes 0 and tens increments.
- pulse=1 and sw1=0 (down):
  - If the count equals 00, it goes to MAX_COUNT and wrap=1 for one cycle.
  - Otherwise it decrements. When ones=0 it borrows: ones becomes 9 and tens decrements.
- Latency: ones/tens/wrap update on the first rising edge after the cycle where pulse is sampled high.
- pulse held high for N cycles gives N steps; no edge detection is done here.
- ones and tens are never non-BCD. The count is never outside 00..MAX_COUNT.
- wrap is 0 on every cycle not listed above.

Display multiplexing:
- Refresh counter runs 0..REFRESH_DIV-1 and then returns to 0.
- On that return, sel toggles.
- sel=0: en0=0, en1=1, glyph source = ones.
- sel=1: en0=1, en1=0, glyph source = tens, or all segments off (seg=7'h7F) when BLANK_LZ=1 and tens=0.
- Exactly one of en0/en1 is low at all times after reset. Both are never low together.
- seg, en0 and en1 are registered and updated every cycle from the current sel and count. A count change therefore shows on seg one cycle after ones/tens change, if that digit is active.
- Active-low glyphs, written as g..a:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- clr and pulse have no effect on the refresh counter or sel.

Test Plan:
- Reset then 12 up pulses (sw1=1), spaced 3 cycles apart → after the last, tens=1, ones=2. wrap never asserted.
- From count 99 (MAX_COUNT=99), one up pulse → count 00 next edge, with wrap=1 for exactly one cycle. Then one down pulse → count 99 and wrap=1 again.
- With MAX_COUNT=15 at count 15, up pulse → 00 with wrap. With count 10, down pulse → 09 (borrow), no wrap.
- clr=1 and pulse=1 in the same cycle at count 37 → count 00, wrap=0.
- REFRESH_DIV=4, count 07, BLANK_LZ=1:
  - en0 is low for 4 cycles with seg=1111000, then en1 is low for 4 cycles with seg=1111111. The pattern repeats.
  - At no cycle are en0 and en1 both low.
- Assert rst_n=0 mid-count (count 58) between clock edges → outputs take their reset values immediately, without a clk edge. After release, the display restarts on units showing "0".

Source files
------------

// File: rtl/pb_bcd_display_if.sv
// ---------------------------------------------------------------------------
// pb_bcd_display_if
//   Groups the event inputs and the count/display outputs of pb_bcd_display
//   so the counter/display stage can be wired with a single port.
//
//   Signals:
//     pulse  single-cycle count event from the upstream pulse stage
//     sw1    count direction, 1 = up, 0 = down
//     clr    synchronous clear of the count, active high
//     ones   BCD units digit
//     tens   BCD tens digit
//     wrap   one-cycle flag marking a count wrap
//     seg    segment cathodes, active low, seg[0]=a .. seg[6]=g
//     en0    units digit anode enable, active low
//     en1    tens digit anode enable, active low
//
//   Modports:
//     master  drives the events, observes count and display
//     slave   the counter/display block itself
// ---------------------------------------------------------------------------
interface pb_bcd_display_if;
   logic       pulse;
   logic       sw1;
   logic       clr;
   logic [3:0] ones;
   logic [3:0] tens;
   logic       wrap;
   logic [6:0] seg;
   logic       en0;
   logic       en1;

   modport master (
      output pulse, sw1, clr,
      input  ones, tens, wrap, seg, en0, en1
   );

   modport slave (
      input  pulse, sw1, clr,
      output ones, tens, wrap, seg, en0, en1
   );
endinterface

// File: rtl/pb_bcd_display.sv
// ---------------------------------------------------------------------------
// pb_bcd_display
//   Two-digit BCD up/down event counter (00..MAX_COUNT, wrapping) driving a
//   time-multiplexed two-digit common-anode seven-segment display.
//
//   Ports:
//     clk    system clock, all state on the rising edge
//     rst_n  asynchronous active-low reset
//     bus    pb_bcd_display_if.slave: pulse/sw1/clr in; ones/tens/wrap,
//            seg/en0/en1 out (all outputs registered)
//
//   Parameters:
//     MAX_COUNT    highest count value, 1..99
//     REFRESH_DIV  clk cycles each digit stays enabled, >= 2
//     BLANK_LZ     when 1, the tens digit is blanked while tens is 0
// ---------------------------------------------------------------------------
module pb_bcd_display #(
   parameter int MAX_COUNT   = 99,
   parameter int REFRESH_DIV = 50000,
   parameter bit BLANK_LZ    = 1'b1
) (
   input  logic                clk,
   input  logic                rst_n,
   pb_bcd_display_if.slave     bus
);

   localparam logic [3:0] MAX_TENS = 4'(MAX_COUNT / 10);
   localparam logic [3:0] MAX_ONES = 4'(MAX_COUNT % 10);
   localparam int         RW       = $clog2(REFRESH_DIV);
   localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_DIV - 1);

   logic [3:0]    r_ones;
   logic [3:0]    r_tens;
   logic          r_wrap;
   logic [RW-1:0] r_refCnt;
   logic          r_sel;
   logic [6:0]    r_seg;
   logic          r_en0;
   logic          r_en1;

   logic [3:0]    w_onesNext;
   logic [3:0]    w_tensNext;
   logic          w_wrapNext;
   logic          w_atMax;
   logic          w_atZero;
   logic [6:0]    w_segNext;

   // Active-low glyph table, bit 6 = g down to bit 0 = a.
   function automatic logic [6:0] glyph(input logic [3:0] digit);
      logic [6:0] g;
      case (digit)
         4'd0:    g = 7'b1000000;
         4'd1:    g = 7'b1111001;
         4'd2:    g = 7'b0100100;
         4'd3:    g = 7'b0110000;
         4'd4:    g = 7'b0011001;
         4'd5:    g = 7'b0010010;
         4'd6:    g = 7'b0000010;
         4'd7:    g = 7'b1111000;
         4'd8:    g = 7'b0000000;
         4'd9:    g = 7'b0010000;
         default: g = 7'b1111111;
      endcase
      return g;
   endfunction

   assign w_atMax  = (r_tens == MAX_TENS) && (r_ones == MAX_ONES);
   assign w_atZero = (r_tens == 4'd0) && (r_ones == 4'd0);

   // Next count: clear beats a pulse, a pulse beats hold. Wrapping happens
   // at the ends of the range; otherwise the BCD digits carry or borrow
   // between units and tens so neither digit ever leaves 0..9.
   always_comb begin
      w_onesNext = r_ones;
      w_tensNext = r_tens;
      w_wrapNext = 1'b0;
      if (bus.clr) begin
         w_onesNext = 4'd0;
         w_tensNext = 4'd0;
      end else if (bus.pulse) begin
         if (bus.sw1) begin
            if (w_atMax) begin
               w_onesNext = 4'd0;
               w_tensNext = 4'd0;
               w_wrapNext = 1'b1;
            end else if (r_ones == 4'd9) begin
               w_onesNext = 4'd0;
               w_tensNext = r_tens + 4'd1;
            end else begin
               w_onesNext = r_ones + 4'd1;
            end
         end else begin
            if (w_atZero) begin
               w_onesNext = MAX_ONES;
               w_tensNext = MAX_TENS;
               w_wrapNext = 1'b1;
            end else if (r_ones == 4'd0) begin
               w_onesNext = 4'd9;
               w_tensNext = r_tens - 4'd1;
            end else begin
               w_onesNext = r_ones - 4'd1;
            end
         end
      end
   end

   // Count and wrap registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ones <= 4'd0;
         r_tens <= 4'd0;
         r_wrap <= 1'b0;
      end else begin
         r_ones <= w_onesNext;
         r_tens <= w_tensNext;
         r_wrap <= w_wrapNext;
      end
   end

   // Refresh timer: each digit stays selected for REFRESH_DIV cycles, and
   // the digit select flips each time the timer rolls back to zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_refCnt <= '0;
         r_sel    <= 1'b0;
      end else if (r_refCnt == REF_LAST) begin
         r_refCnt <= '0;
         r_sel    <= ~r_sel;
      end else begin
         r_refCnt <= r_refCnt + 1'b1;
      end
   end

   // Segment source for the selected digit; the tens digit can be blanked
   // to suppress a leading zero.
   always_comb begin
      w_segNext = glyph(r_ones);
      if (r_sel) begin
         if (BLANK_LZ && (r_tens == 4'd0)) begin
            w_segNext = 7'b1111111;
         end else begin
            w_segNext = glyph(r_tens);
         end
      end
   end

   // Registered display drive. The enables are complementary copies of the
   // select, so exactly one anode is active on every cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_seg <= 7'b1000000;
         r_en0 <= 1'b0;
         r_en1 <= 1'b1;
      end else begin
         r_seg <= w_segNext;
         r_en0 <= r_sel;
         r_en1 <= ~r_sel;
      end
   end

   assign bus.ones = r_ones;
   assign bus.tens = r_tens;
   assign bus.wrap = r_wrap;
   assign bus.seg  = r_seg;
   assign bus.en0  = r_en0;
   assign bus.en1  = r_en1;

endmodule

// File: tb/tb_pb_bcd_display.sv
// ---------------------------------------------------------------------------
// tb_pb_bcd_display
//   Directed bench for pb_bcd_display. Two instances share clock and reset:
//   dutA with MAX_COUNT=99 and dutB with MAX_COUNT=15, both REFRESH_DIV=4
//   and BLANK_LZ=1. Inputs change and outputs are sampled on the falling
//   edge, away from the active rising edge.
// ---------------------------------------------------------------------------
module tb_pb_bcd_display;

   logic clk;
   logic rst_n;

   int vectors;
   int miscompares;
   bit wrapSeenA;

   pb_bcd_display_if ifA ();
   pb_bcd_display_if ifB ();

   pb_bcd_display #(
      .MAX_COUNT   (99),
      .REFRESH_DIV (4),
      .BLANK_LZ    (1'b1)
   ) dutA (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifA)
   );

   pb_bcd_display #(
      .MAX_COUNT   (15),
      .REFRESH_DIV (4),
      .BLANK_LZ    (1'b1)
   ) dutB (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifB)
   );

   // Free-running 10-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Remembers whether dutA ever raised wrap during the up-count run.
   always @(negedge clk) begin
      if (ifA.wrap) wrapSeenA = 1'b1;
   end

   // Single point of comparison: counts the vector and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      vectors++;
      if (observed !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: observed 'h%0h, expected 'h%0h", tag, observed, expected);
      end
   endtask

   // One-cycle event on the chosen instance; returns on the falling edge
   // just after the sampling edge, where the new count is visible.
   task automatic applyStimulus(input bit toB, input logic p, input logic s,
                                input logic c);
      @(negedge clk);
      if (toB) begin
         ifB.pulse = p; ifB.sw1 = s; ifB.clr = c;
      end else begin
         ifA.pulse = p; ifA.sw1 = s; ifA.clr = c;
      end
      @(negedge clk);
      ifA.pulse = 1'b0; ifA.clr = 1'b0;
      ifB.pulse = 1'b0; ifB.clr = 1'b0;
   endtask

   // Holds pulse high for n cycles, giving n count steps.
   task automatic holdPulse(input bit toB, input logic s, input int n);
      @(negedge clk);
      if (toB) begin
         ifB.pulse = 1'b1; ifB.sw1 = s;
      end else begin
         ifA.pulse = 1'b1; ifA.sw1 = s;
      end
      repeat (n) @(negedge clk);
      ifA.pulse = 1'b0;
      ifB.pulse = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic checkCount(input string tag, input int expTens,
                             input int expOnes, input int expWrap);
      checkOutput({tag, ".tens"}, 32'(ifA.tens), expTens);
      checkOutput({tag, ".ones"}, 32'(ifA.ones), expOnes);
      checkOutput({tag, ".wrap"}, 32'(ifA.wrap), expWrap);
   endtask

   task automatic checkCountB(input string tag, input int expTens,
                              input int expOnes, input int expWrap);
      checkOutput({tag, ".tens"}, 32'(ifB.tens), expTens);
      checkOutput({tag, ".ones"}, 32'(ifB.ones), expOnes);
      checkOutput({tag, ".wrap"}, 32'(ifB.wrap), expWrap);
   endtask

   // Aligns to the first cycle of a units window on dutA, then checks the
   // enables and segments for the given number of cycles: four cycles of
   // units, four of tens, repeating.
   task automatic checkDisplay(input string tag, input int segOnes,
                               input int segTens, input int cycles);
      bit found;
      bit prevEn0;
      found   = 1'b0;
      prevEn0 = ifA.en0;
      for (int k = 0; k < 20 && !found; k++) begin
         @(negedge clk);
         if (prevEn0 && !ifA.en0) found = 1'b1;
         prevEn0 = ifA.en0;
      end
      checkOutput({tag, ".align"}, 32'(found), 1);
      if (found) begin
         for (int i = 0; i < cycles; i++) begin
            if (i > 0) @(negedge clk);
            if (((i / 4) % 2) == 0) begin
               checkOutput({tag, ".en0"}, 32'(ifA.en0), 0);
               checkOutput({tag, ".en1"}, 32'(ifA.en1), 1);
               checkOutput({tag, ".seg"}, 32'(ifA.seg), segOnes);
            end else begin
               checkOutput({tag, ".en0"}, 32'(ifA.en0), 1);
               checkOutput({tag, ".en1"}, 32'(ifA.en1), 0);
               checkOutput({tag, ".seg"}, 32'(ifA.seg), segTens);
            end
         end
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      wrapSeenA   = 1'b0;
      ifA.pulse = 1'b0; ifA.sw1 = 1'b1; ifA.clr = 1'b0;
      ifB.pulse = 1'b0; ifB.sw1 = 1'b1; ifB.clr = 1'b0;
      rst_n = 1'b0;
      idle(3);
      rst_n = 1'b1;
      idle(1);

      // Reset state.
      checkCount("reset", 0, 0, 0);
      checkOutput("reset.en0", 32'(ifA.en0), 0);
      checkOutput("reset.en1", 32'(ifA.en1), 1);
      checkOutput("reset.seg", 32'(ifA.seg), 'h40);

      // Twelve up pulses, three cycles apart: 12, never wrapping.
      wrapSeenA = 1'b0;
      for (int i = 0; i < 12; i++) begin
         applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
         idle(2);
      end
      checkCount("up12", 1, 2, 0);
      checkOutput("up12.noWrap", 32'(wrapSeenA), 0);

      // Count 12 on the display: units "2", tens "1".
      checkDisplay("disp12", 'h24, 'h79, 8);

      // Clear, then down from 00 wraps to 99.
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
      checkCount("clr", 0, 0, 0);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      checkCount("down00", 9, 9, 1);
      idle(1);
      checkOutput("down00.wrapDrop", 32'(ifA.wrap), 0);

      // Up from 99 wraps to 00, wrap for one cycle; then down back to 99.
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
      checkCount("up99", 0, 0, 1);
      idle(1);
      checkOutput("up99.wrapDrop", 32'(ifA.wrap), 0);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      checkCount("down00b", 9, 9, 1);
      idle(1);
      checkOutput("down00b.wrapDrop", 32'(ifA.wrap), 0);

      // Up with carry and down with borrow across a tens boundary.
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
      holdPulse(1'b0, 1'b1, 9);
      checkCount("hold9", 0, 9, 0);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
      checkCount("carry", 1, 0, 0);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      checkCount("borrow", 0, 9, 0);

      // Held pulse to 37, then clear and pulse together: clear wins.
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
      holdPulse(1'b0, 1'b1, 37);
      checkCount("hold37", 3, 7, 0);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
      checkCount("clrPulse", 0, 0, 0);

      // Count 07: units "7" for four cycles, blanked tens for four, twice.
      holdPulse(1'b0, 1'b1, 7);
      checkCount("hold7", 0, 7, 0);
      checkDisplay("disp07", 'h78, 'h7F, 16);

      // MAX_COUNT=15 instance: wrap at 15 and borrow from 10.
      holdPulse(1'b1, 1'b1, 15);
      checkCountB("b.hold15", 1, 5, 0);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
      checkCountB("b.up15", 0, 0, 1);
      idle(1);
      checkOutput("b.up15.wrapDrop", 32'(ifB.wrap), 0);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      checkCountB("b.down00", 1, 5, 1);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
      holdPulse(1'b1, 1'b1, 10);
      checkCountB("b.hold10", 1, 0, 0);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      checkCountB("b.borrow", 0, 9, 0);

      // Asynchronous reset mid-count at 58, between clock edges.
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
      holdPulse(1'b0, 1'b1, 58);
      checkCount("hold58", 5, 8, 0);
      idle(5);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checkCount("asyncRst", 0, 0, 0);
      checkOutput("asyncRst.en0", 32'(ifA.en0), 0);
      checkOutput("asyncRst.en1", 32'(ifA.en1), 1);
      checkOutput("asyncRst.seg", 32'(ifA.seg), 'h40);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkOutput("restart.en0", 32'(ifA.en0), 0);
         checkOutput("restart.en1", 32'(ifA.en1), 1);
         checkOutput("restart.seg", 32'(ifA.seg), 'h40);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
